// File: rtl/step_pkg.sv
// rtl/step_pkg.sv - shared motion-bus types and defaults for step decoding
package step_pkg;

  localparam int unsigned POS_W = 32;

  localparam int unsigned DEFAULT_FILTER_LEN = 4;
  localparam int unsigned DEFAULT_DIR_SETUP  = 50;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURING
  } period_state_t;

endpackage

// File: rtl/sync_filter.sv
// rtl/sync_filter.sv - 2-FF synchronizer followed by a FILTER_LEN glitch filter
module sync_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic filtered
);

  logic       meta;
  logic       sync;
  logic [7:0] cnt;

  // filtered follows sync only once it has differed for more than FILTER_LEN samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta     <= 1'b0;
      sync     <= 1'b0;
      cnt      <= '0;
      filtered <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (sync != filtered) begin
        if (cnt == 8'(FILTER_LEN)) begin
          filtered <= sync;
          cnt      <= '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/step_decoder.sv
// rtl/step_decoder.sv - step/dir stream decoder: position, period and dir-setup check
module step_decoder
  import step_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DEFAULT_FILTER_LEN,
  parameter int unsigned DIR_SETUP  = DEFAULT_DIR_SETUP,
  parameter int unsigned PERIOD_W   = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                step_in,
  input  logic                dir_in,
  input  logic [POS_W-1:0]    data_in,
  input  logic                set_position,
  input  logic                clear_err,
  output logic [POS_W-1:0]    position,
  output logic                step_strobe,
  output logic                dir_out,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                timeout,
  output logic                setup_err
);

  localparam logic [15:0]         SETUP_MIN = 16'(DIR_SETUP);
  localparam logic [PERIOD_W-1:0] PMAX      = '1;
  localparam logic [PERIOD_W-1:0] PLAST     = PMAX - PERIOD_W'(1);

  logic          step_f, dir_f;
  logic          step_prev, dir_prev;
  logic          step_rise, dir_change, setup_bad;
  logic [15:0]   setup_cnt;
  logic [PERIOD_W-1:0] pcnt;
  logic          pcnt_last;
  period_state_t state, state_nxt;

  sync_filter #(.FILTER_LEN(FILTER_LEN)) u_step_filter (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw      (step_in),
    .filtered (step_f)
  );

  sync_filter #(.FILTER_LEN(FILTER_LEN)) u_dir_filter (
    .clk      (clk),
    .reset_n  (reset_n),
    .raw      (dir_in),
    .filtered (dir_f)
  );

  assign step_rise  = step_f & ~step_prev;
  assign dir_change = dir_f ^ dir_prev;
  assign setup_bad  = dir_change || (setup_cnt < SETUP_MIN);
  assign pcnt_last  = (state != IDLE) && (pcnt == PLAST);

  // setup_cnt starts saturated so the first step after reset is not flagged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_prev   <= 1'b0;
      dir_prev    <= 1'b0;
      setup_cnt   <= SETUP_MIN;
      position    <= '0;
      step_strobe <= 1'b0;
      dir_out     <= 1'b0;
      setup_err   <= 1'b0;
    end else begin
      step_prev   <= step_f;
      dir_prev    <= dir_f;
      step_strobe <= 1'b0;
      if (dir_change) begin
        setup_cnt <= 16'd1;
      end else if (setup_cnt < SETUP_MIN) begin
        setup_cnt <= setup_cnt + 16'd1;
      end
      if (set_position) begin
        position <= data_in;
      end else if (step_rise) begin
        position    <= dir_f ? position - POS_W'(1) : position + POS_W'(1);
        step_strobe <= 1'b1;
        dir_out     <= dir_f;
      end
      setup_err <= (setup_err & ~clear_err) | (step_rise & setup_bad);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (set_position) begin
      state_nxt = IDLE;
    end else if (step_strobe) begin
      state_nxt = (state == IDLE) ? ARMED : MEASURING;
    end else if (pcnt_last) begin
      state_nxt = IDLE;
    end
  end

  // period tracking runs one cycle behind the strobe, so distances are strobe-to-strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      if (set_position) begin
        pcnt         <= '0;
        period_valid <= 1'b0;
      end else if (step_strobe) begin
        pcnt    <= '0;
        timeout <= 1'b0;
        if (state != IDLE) begin
          period       <= pcnt + PERIOD_W'(1);
          period_valid <= 1'b1;
        end
      end else if (state != IDLE && pcnt != PMAX) begin
        pcnt <= pcnt + PERIOD_W'(1);
        if (pcnt_last) begin
          timeout      <= 1'b1;
          period_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_step_decoder.sv
// tb/tb_step_decoder.sv - self-checking bench for step_decoder against a pulse-level model
module tb_step_decoder;

  localparam int unsigned FL = 4;
  localparam int unsigned DS = 50;

  logic        clk;
  logic        reset_n;
  logic        step_in;
  logic        dir_in;
  logic [31:0] data_in;
  logic        set_position;
  logic        clear_err;

  logic [31:0] position;
  logic        step_strobe;
  logic        dir_out;
  logic [31:0] period;
  logic        period_valid;
  logic        timeout;
  logic        setup_err;

  logic [31:0] position8;
  logic        step_strobe8;
  logic        dir_out8;
  logic [7:0]  period8;
  logic        period_valid8;
  logic        timeout8;
  logic        setup_err8;

  step_decoder #(.FILTER_LEN(FL), .DIR_SETUP(DS), .PERIOD_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .step_in(step_in), .dir_in(dir_in),
    .data_in(data_in), .set_position(set_position), .clear_err(clear_err),
    .position(position), .step_strobe(step_strobe), .dir_out(dir_out),
    .period(period), .period_valid(period_valid), .timeout(timeout),
    .setup_err(setup_err)
  );

  step_decoder #(.FILTER_LEN(FL), .DIR_SETUP(DS), .PERIOD_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .step_in(step_in), .dir_in(dir_in),
    .data_in(data_in), .set_position(set_position), .clear_err(clear_err),
    .position(position8), .step_strobe(step_strobe8), .dir_out(dir_out8),
    .period(period8), .period_valid(period_valid8), .timeout(timeout8),
    .setup_err(setup_err8)
  );

  int checks;
  int failures;
  int cyc;
  int strobe_cnt;

  // model state: position, direction, and strobe-to-strobe distance from step_in rises
  logic [31:0] pos_m;
  logic        dir_m;
  bit          armed_m;
  bit          valid_m;
  int          last_rise;
  int          per_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;
  always @(negedge clk) if (reset_n && step_strobe) strobe_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_pos(input logic [31:0] v);
    data_in      = v;
    set_position = 1'b1;
    tick(1);
    set_position = 1'b0;
    pos_m   = v;
    armed_m = 0;
    valid_m = 0;
  endtask

  task automatic set_dir(input logic d, input int wait_cycles);
    dir_in = d;
    dir_m  = d;
    tick(wait_cycles);
  endtask

  task automatic pulse(input int hi, input int lo);
    int rise;
    step_in = 1'b1;
    rise    = cyc;
    tick(hi);
    step_in = 1'b0;
    tick(lo);
    if (hi >= int'(FL) + 1) begin
      pos_m = dir_m ? pos_m - 32'd1 : pos_m + 32'd1;
      if (armed_m) begin
        per_m   = rise - last_rise;
        valid_m = 1;
      end
      armed_m   = 1;
      last_rise = rise;
    end
  endtask

  initial begin
    int s0, n, rise, hi, lo;
    bit got;
    checks = 0; failures = 0; cyc = 0; strobe_cnt = 0;
    pos_m = '0; dir_m = 0; armed_m = 0; valid_m = 0; last_rise = 0; per_m = 0;
    reset_n = 1'b0; step_in = 1'b0; dir_in = 1'b0; data_in = '0;
    set_position = 1'b0; clear_err = 1'b0;
    tick(5);
    chk("rst_position", position, 32'd0);
    chk("rst_strobe", {31'd0, step_strobe}, 32'd0);
    chk("rst_dir_out", {31'd0, dir_out}, 32'd0);
    chk("rst_period", period, 32'd0);
    chk("rst_period_valid", {31'd0, period_valid}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_setup_err", {31'd0, setup_err}, 32'd0);
    reset_n = 1'b1;
    tick(5);

    // three clean pulses, period 600
    repeat (3) pulse(500, 100);
    chk("clean_position", position, pos_m);
    chk("clean_position_abs", position, 32'd3);
    chk("clean_period", period, per_m);
    chk("clean_period_abs", period, 32'd600);
    chk("clean_period_valid", {31'd0, period_valid}, 32'd1);
    chk("clean_setup_err", {31'd0, setup_err}, 32'd0);

    // reverse direction and wrap in both directions
    set_pos(32'd0);
    set_dir(1'b1, 100);
    repeat (5) pulse(20, 20);
    chk("rev_position", position, pos_m);
    chk("rev_position_abs", position, 32'hFFFF_FFFB);
    chk("rev_dir_out", {31'd0, dir_out}, 32'd1);
    set_pos(32'd0);
    pulse(20, 20);
    chk("wrap_down", position, 32'hFFFF_FFFF);
    set_pos(32'hFFFF_FFFF);
    set_dir(1'b0, 100);
    pulse(20, 20);
    chk("wrap_up", position, 32'd0);
    chk("wrap_up_dir_out", {31'd0, dir_out}, 32'd0);
    chk("wrap_setup_err", {31'd0, setup_err}, 32'd0);

    // glitch rejection and strobe latency
    s0 = strobe_cnt;
    step_in = 1'b1;
    tick(3);
    step_in = 1'b0;
    tick(50);
    chk("glitch_no_strobe", strobe_cnt - s0, 32'd0);
    chk("glitch_position", position, pos_m);
    s0 = strobe_cnt;
    step_in = 1'b1;
    n = 0;
    got = 0;
    for (int i = 1; i <= 30 && !got; i++) begin
      tick(1);
      if (i == 5) step_in = 1'b0;
      if (step_strobe) begin
        got = 1;
        n = i;
      end
    end
    pos_m = pos_m + 32'd1;
    armed_m = 0;
    tick(50);
    chk("pulse5_latency", n, FL + 4);
    chk("pulse5_one_strobe", strobe_cnt - s0, 32'd1);
    chk("pulse5_position", position, pos_m);

    // dir changed 10 cycles before a step
    set_dir(~dir_m, 10);
    pulse(20, 100);
    chk("setup_err_set", {31'd0, setup_err}, 32'd1);
    chk("setup_step_counted", position, pos_m);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    chk("setup_err_cleared", {31'd0, setup_err}, 32'd0);
    set_dir(1'b0, 100);

    // set_position coinciding with a strobe drops the step
    step_in = 1'b1;
    tick(7);
    data_in = 32'h1234;
    set_position = 1'b1;
    tick(1);
    set_position = 1'b0;
    pos_m = 32'h1234; armed_m = 0; valid_m = 0;
    chk("setpos_position", position, 32'h1234);
    chk("setpos_period_valid", {31'd0, period_valid}, 32'd0);
    tick(12);
    step_in = 1'b0;
    tick(100);
    chk("setpos_dropped", position, 32'h1234);
    pulse(20, 100);
    chk("setpos_one_step_valid", {31'd0, period_valid}, 32'd0);
    chk("setpos_one_step_pos", position, pos_m);
    pulse(20, 100);
    chk("setpos_two_step_valid", {31'd0, period_valid}, 32'd1);
    chk("setpos_two_step_period", period, per_m);

    // 8-bit period counter timeout
    pulse(20, 100);
    tick(300);
    chk("to8_timeout", {31'd0, timeout8}, 32'd1);
    chk("to8_period_valid", {31'd0, period_valid8}, 32'd0);
    chk("to32_no_timeout", {31'd0, timeout}, 32'd0);
    pulse(20, 100);
    chk("to8_timeout_cleared", {31'd0, timeout8}, 32'd0);
    chk("to8_period_kept", {24'd0, period8}, 32'd120);
    chk("to32_long_period", period, per_m);
    chk("to32_long_period_abs", period, 32'd420);

    // randomized pulse stream against the model
    set_pos($urandom);
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: set_dir(~dir_m, DS + 5 + $urandom_range(0, 20));
        1: begin
          step_in = 1'b1;
          tick($urandom_range(1, FL));
          step_in = 1'b0;
          tick(FL + 1 + $urandom_range(0, 10));
        end
        2: set_pos($urandom);
        default: begin
          hi = $urandom_range(FL + 1, 30);
          lo = $urandom_range(FL + 1, 30);
          pulse(hi, lo);
        end
      endcase
      tick(FL + 4);
      chk("rand_position", position, pos_m);
      chk("rand_period_valid", {31'd0, period_valid}, {31'd0, valid_m});
      if (valid_m) chk("rand_period", period, per_m);
    end
    chk("rand_setup_err", {31'd0, setup_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
